// File: rtl/rlwe_instr_sequencer.sv
// Host-side command sequencer for one rlwe_top core: queues instruction codes,
// resets the core, issues each code, waits for done and returns one status per command.
module rlwe_instr_sequencer #(
  parameter bit CORE_INDEX   = 1'b1,
  parameter int DEPTH        = 8,
  parameter int CORE_RST_CYC = 2,
  parameter int TIMEOUT_W    = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_code,
  input  logic                     cmd_modsel,
  output logic [7:0]               core_instruction,
  output logic                     core_modulus_sel,
  output logic                     core_rst,
  input  logic                     core_done,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [7:0]               rsp_code,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [2:0]               fsm_state
);

  // Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready;
  // a response transfers on rsp_valid && rsp_ready, and rsp_code/rsp_status
  // are held stable from the rise of rsp_valid until that transfer.

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = (CORE_RST_CYC > 1) ? $clog2(CORE_RST_CYC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CRST  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;

  localparam logic [RCW-1:0]       RST_LOAD = RCW'(CORE_RST_CYC - 1);
  // Last watchdog value before it would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [8:0]           mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [8:0]           head;
  logic                 head_legal;
  logic                 push;
  logic                 pop;

  logic [2:0]           state;
  logic [7:0]           hold_code;
  logic [RCW-1:0]       rst_cnt;
  logic [TIMEOUT_W-1:0] wd;

  assign cmd_ready   = (count != CW'(DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == S_IDLE) && (count != '0);
  assign head        = mem[rd_ptr];
  assign head_legal  = ((head[7:0] >= 8'd17) && (head[7:0] <= 8'd20)) ||
                       ((head[7:0] == 8'd16) && !CORE_INDEX);
  assign queue_count = count;
  assign busy        = (state != S_IDLE) || (count != '0);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_modsel, cmd_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      core_rst         <= 1'b1;
      core_instruction <= 8'd0;
      core_modulus_sel <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_code         <= 8'd0;
      rsp_status       <= ST_OK;
      hold_code        <= 8'd0;
      rst_cnt          <= '0;
      wd               <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          core_rst         <= 1'b1;
          core_instruction <= 8'd0;
          if (pop) begin
            hold_code <= head[7:0];
            if (!head_legal) begin
              // Illegal codes never reach the core.
              state      <= S_RESP;
              rsp_valid  <= 1'b1;
              rsp_code   <= head[7:0];
              rsp_status <= ST_ILLEGAL;
            end else begin
              state            <= S_CRST;
              core_modulus_sel <= head[8];
              rst_cnt          <= RST_LOAD;
            end
          end
        end
        S_CRST: begin
          // core_done may still be high from the previous op; ignored here.
          if (rst_cnt == '0) begin
            state            <= S_ISSUE;
            core_rst         <= 1'b0;
            core_instruction <= hold_code;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end
        S_ISSUE: begin
          core_instruction <= 8'd0;
          wd               <= '0;
          state            <= S_WAIT;
        end
        S_WAIT: begin
          if (core_done) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_code   <= hold_code;
            rsp_status <= ST_OK;
          end else if (wd == WD_LAST) begin
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_code   <= hold_code;
            rsp_status <= ST_TIMEOUT;
          end else begin
            wd <= wd + TIMEOUT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            core_rst  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rlwe_instr_sequencer.sv
// Bench for rlwe_instr_sequencer: a transaction-level model predicts every output
// each cycle from the command stream; a small core model answers issued codes.
module tb_rlwe_instr_sequencer;

  localparam bit CI    = 1'b1;
  localparam int DEPTH = 8;
  localparam int CRST  = 2;
  localparam int TW    = 6;
  localparam int LIMIT = (1 << TW) - 1;
  localparam int NEVER = 100000;

  typedef struct {
    logic [7:0] code;
    logic       modsel;
    int         delay;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_code = 8'd0;
  logic        cmd_modsel = 1'b0;
  logic [7:0]  core_instruction;
  logic        core_modulus_sel;
  logic        core_rst;
  logic        core_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_code;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [3:0]  queue_count;
  logic [2:0]  fsm_state;

  rlwe_instr_sequencer #(
    .CORE_INDEX(CI), .DEPTH(DEPTH), .CORE_RST_CYC(CRST), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_modsel(cmd_modsel),
    .core_instruction(core_instruction), .core_modulus_sel(core_modulus_sel),
    .core_rst(core_rst), .core_done(core_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code), .rsp_status(rsp_status),
    .busy(busy), .queue_count(queue_count), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int drv_delay = 1;
  int rr_mode = 0;
  logic [9:0] exp_q[$];
  cmd_t       mq[$];
  cmd_t       cur;
  logic       inflight = 1'b0;
  logic       cur_legal = 1'b0;
  int         issue_cyc = 0;
  int         rsp_rise = 0;
  int         t_done = -1;
  int         rst_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    $display("FAIL %s wait bound expired time=%0t", name, $time);
  endtask

  function automatic bit legal(input logic [7:0] c);
    return ((c >= 8'd17) && (c <= 8'd20)) || ((c == 8'd16) && !CI);
  endfunction

  // ---------------- model, per-cycle compare, core stand-in ----------------
  always @(negedge clk) begin
    bit   can_push, pop, hs, e_rv;
    cmd_t nc;
    int   w;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      inflight  = 1'b0;
      core_done = 1'b0;
      t_done    = -1;
      rst_run   = 0;
    end else begin
      e_rv = inflight && (cyc >= rsp_rise);
      chk("core_rst", core_rst, !(inflight && cur_legal && cyc >= issue_cyc));
      chk("core_instruction", core_instruction,
          (inflight && cur_legal && cyc == issue_cyc) ? cur.code : 8'd0);
      if (inflight && cur_legal) chk("core_modulus_sel", core_modulus_sel, cur.modsel);
      chk("queue_count", queue_count, mq.size());
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("busy", busy, inflight || (mq.size() != 0));
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv && exp_q.size() != 0) chk("rsp_fields", {rsp_status, rsp_code}, exp_q[0]);

      // Core stand-in: done rises `delay` cycles after issue and is sticky
      // until core_rst has been seen for three cycles (slow reset).
      if (core_rst) begin
        rst_run++;
        if (rst_run >= 3) core_done = 1'b0;
        t_done = -1;
      end else begin
        rst_run = 0;
        if (core_instruction != 8'd0 && inflight) t_done = cyc + cur.delay;
        if (cyc == t_done) core_done = 1'b1;
      end

      can_push = cmd_valid && (mq.size() < DEPTH);
      pop      = !inflight && (mq.size() != 0);
      hs       = e_rv && rsp_ready;
      if (pop) begin
        cur       = mq.pop_front();
        inflight  = 1'b1;
        cur_legal = legal(cur.code);
        if (cur_legal) begin
          issue_cyc = cyc + CRST + 1;
          w = (cur.delay <= LIMIT) ? cur.delay : LIMIT;
          rsp_rise  = issue_cyc + w + 1;
          exp_q.push_back({((cur.delay <= LIMIT) ? 2'd0 : 2'd1), cur.code});
        end else begin
          rsp_rise = cyc + 1;
          exp_q.push_back({2'd2, cur.code});
        end
      end
      if (can_push) begin
        nc.code = cmd_code; nc.modsel = cmd_modsel; nc.delay = drv_delay;
        mq.push_back(nc);
      end
      if (hs) begin
        inflight = 1'b0;
        void'(exp_q.pop_front());
      end
    end
    cyc++;
  end

  // ---------------- rsp_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] code, input logic ms, input int dly);
    int n = 0;
    cmd_code = code; cmd_modsel = ms; drv_delay = dly; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 3000) begin n++; @(negedge clk); end
    if (n >= 3000) bound_fail("push");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || inflight || mq.size() != 0) && n < 6000) begin n++; @(negedge clk); end
    if (n >= 6000) bound_fail("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(input logic [7:0] code, input logic [1:0] st, output int cycles);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 3000) begin n++; @(negedge clk); end
    cycles = n;
    if (n >= 3000) bound_fail("wait_rsp");
    else begin
      chk("pin_rsp_code", rsp_code, code);
      chk("pin_rsp_status", rsp_status, st);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, seen;
    // reset values
    idle(3);
    chk("reset_core_rst", core_rst, 1'b1);
    chk("reset_core_instruction", core_instruction, 8'd0);
    chk("reset_core_modulus_sel", core_modulus_sel, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_code", rsp_code, 8'd0);
    chk("reset_rsp_status", rsp_status, 2'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_queue_count", queue_count, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // single command, done 50 cycles after issue
    push(8'h11, 1'b1, 50);
    n = 0;
    @(negedge clk);
    while (core_instruction == 8'd0 && n < 20) begin n++; @(negedge clk); end
    chk("pin_issue_latency", n, 3);
    chk("pin_issue_code", core_instruction, 8'h11);
    chk("pin_issue_modsel", core_modulus_sel, 1'b1);
    chk("pin_issue_rst", core_rst, 1'b0);
    @(negedge clk);
    chk("pin_issue_one_cycle", core_instruction, 8'd0);
    @(posedge clk); #1;
    wait_rsp(8'h11, 2'd0, n);
    chk("pin_done_to_rsp", n, 49);
    wait_idle();

    // back-to-back legal commands
    push(8'h13, 1'b0, 3);
    push(8'h14, 1'b1, 7);
    push(8'h12, 1'b0, 1);
    wait_idle();

    // illegal codes: 16 with CORE_INDEX=1, and 7
    push(8'h10, 1'b1, 5);
    push(8'h07, 1'b0, 5);
    wait_idle();

    // backpressure: nine commands with responses blocked
    rr_mode = 1;
    idle(1);
    for (int i = 0; i < 9; i++) push(8'(8'h11 + (i % 4)), 1'(i % 2), 5);
    @(negedge clk);
    chk("pin_full_count", queue_count, 4'd8);
    chk("pin_full_ready", cmd_ready, 1'b0);
    idle(30);
    rr_mode = 0;
    wait_idle();

    // watchdog boundary
    push(8'h12, 1'b1, LIMIT);
    push(8'h13, 1'b0, LIMIT + 1);
    push(8'h14, 1'b1, NEVER);
    wait_rsp(8'h12, 2'd0, n);
    wait_rsp(8'h13, 2'd1, n);
    wait_rsp(8'h14, 2'd1, n);
    wait_idle();

    // randomized traffic
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      if (r < 2)       d = LIMIT + $urandom_range(0, 1);
      else if (r == 2) d = 200;
      else             d = $urandom_range(1, 40);
      push(8'($urandom_range(14, 22)), 1'($urandom_range(0, 1)), d);
      idle($urandom_range(0, 3));
    end
    rr_mode = 0;
    wait_idle();

    // reset during WAIT with three commands queued
    push(8'h11, 1'b1, NEVER);
    idle(10);
    push(8'h12, 1'b0, 5);
    push(8'h13, 1'b1, 5);
    push(8'h14, 1'b0, 5);
    @(negedge clk);
    chk("pin_pre_reset_count", queue_count, 4'd3);
    chk("pin_pre_reset_core_rst", core_rst, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_core_rst", core_rst, 1'b1);
    chk("async_core_instruction", core_instruction, 8'd0);
    chk("async_core_modulus_sel", core_modulus_sel, 1'b0);
    chk("async_rsp_valid", rsp_valid, 1'b0);
    chk("async_queue_count", queue_count, 4'd0);
    chk("async_busy", busy, 1'b0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("pin_no_rsp_after_reset", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
